// File: rtl/rename_reg_file.sv
// Architectural register file with per-register rename tags for an OoO core.
// Optional macro RF_BYPASS_EN forwards a tag-matching commit onto the read ports.
module rename_reg_file #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32,
  parameter int ROB_ID_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                clear,
  input  logic [4:0]          rs1_id,
  input  logic [4:0]          rs2_id,
  output logic [XLEN-1:0]     rs1_val,
  output logic                rs1_busy,
  output logic [ROB_ID_W-1:0] rs1_tag,
  output logic [XLEN-1:0]     rs2_val,
  output logic                rs2_busy,
  output logic [ROB_ID_W-1:0] rs2_tag,
  input  logic                issue_en,
  input  logic [4:0]          issue_rd,
  input  logic [ROB_ID_W-1:0] issue_rob_id,
  input  logic                commit_en,
  input  logic [4:0]          commit_rd,
  input  logic [ROB_ID_W-1:0] commit_rob_id,
  input  logic [XLEN-1:0]     commit_val
);

  logic [XLEN-1:0]     val_r  [NUM_REGS];
  logic                busy_r [NUM_REGS];
  logic [ROB_ID_W-1:0] tag_r  [NUM_REGS];

  logic commit_ok_s;
  logic issue_ok_s;

  // Qualified write strobes; x0 is never written so it reads as zero forever.
  always_comb begin
    commit_ok_s = rdy && commit_en && (commit_rd != 5'd0);
    issue_ok_s  = rdy && issue_en && !clear && (issue_rd != 5'd0);
  end

  // State update: commit release first, then flush/issue so a same-cycle rename wins busy/tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        val_r[i]  <= {XLEN{1'b0}};
        busy_r[i] <= 1'b0;
        tag_r[i]  <= {ROB_ID_W{1'b0}};
      end
    end else begin
      if (commit_ok_s) begin
        val_r[commit_rd] <= commit_val;
        if (busy_r[commit_rd] && (tag_r[commit_rd] == commit_rob_id)) begin
          busy_r[commit_rd] <= 1'b0;
        end
      end
      if (rdy && clear) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          busy_r[i] <= 1'b0;
        end
      end else if (issue_ok_s) begin
        busy_r[issue_rd] <= 1'b1;
        tag_r[issue_rd]  <= issue_rob_id;
      end
    end
  end

  // Source-1 read port.
  always_comb begin
    rs1_val  = {XLEN{1'b0}};
    rs1_busy = 1'b0;
    rs1_tag  = {ROB_ID_W{1'b0}};
    if (rs1_id != 5'd0) begin
      rs1_val  = val_r[rs1_id];
      rs1_busy = busy_r[rs1_id];
      rs1_tag  = tag_r[rs1_id];
`ifdef RF_BYPASS_EN
      if (commit_en && !clear && (rs1_id == commit_rd) && busy_r[rs1_id]
          && (tag_r[rs1_id] == commit_rob_id)) begin
        rs1_val  = commit_val;
        rs1_busy = 1'b0;
      end else begin
        rs1_busy = busy_r[rs1_id];
      end
`endif
    end else begin
      rs1_busy = 1'b0;
    end
  end

  // Source-2 read port.
  always_comb begin
    rs2_val  = {XLEN{1'b0}};
    rs2_busy = 1'b0;
    rs2_tag  = {ROB_ID_W{1'b0}};
    if (rs2_id != 5'd0) begin
      rs2_val  = val_r[rs2_id];
      rs2_busy = busy_r[rs2_id];
      rs2_tag  = tag_r[rs2_id];
`ifdef RF_BYPASS_EN
      if (commit_en && !clear && (rs2_id == commit_rd) && busy_r[rs2_id]
          && (tag_r[rs2_id] == commit_rob_id)) begin
        rs2_val  = commit_val;
        rs2_busy = 1'b0;
      end else begin
        rs2_busy = busy_r[rs2_id];
      end
`endif
    end else begin
      rs2_busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_rename_reg_file.sv
// Directed self-checking bench for rename_reg_file.
module tb_rename_reg_file;

  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic [4:0]  rs1_id, rs2_id;
  logic [31:0] rs1_val, rs2_val;
  logic        rs1_busy, rs2_busy;
  logic [3:0]  rs1_tag, rs2_tag;
  logic        issue_en, commit_en;
  logic [4:0]  issue_rd, commit_rd;
  logic [3:0]  issue_rob_id, commit_rob_id;
  logic [31:0] commit_val;

  int total = 0;
  int bad   = 0;

  rename_reg_file dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_val(rs1_val), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
    .rs2_val(rs2_val), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag),
    .issue_en(issue_en), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_rob_id(commit_rob_id),
    .commit_val(commit_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_en = 1'b0; commit_en = 1'b0; clear = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; clear = 1'b0;
    rs1_id = 5'd5; rs2_id = 5'd7;
    issue_en = 1'b0; issue_rd = 5'd0; issue_rob_id = 4'd0;
    commit_en = 1'b0; commit_rd = 5'd0; commit_rob_id = 4'd0; commit_val = 32'd0;
    #1;
    chk("reset_val", rs1_val, 32'd0);
    chk("reset_busy", {31'd0, rs1_busy}, 32'd0);
    chk("reset_tag", {28'd0, rs1_tag}, 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // rename then commit
    issue_en = 1'b1; issue_rd = 5'd5; issue_rob_id = 4'd3;
    tick(); idle();
    #1;
    chk("ren_busy", {31'd0, rs1_busy}, 32'd1);
    chk("ren_tag", {28'd0, rs1_tag}, 32'd3);
    commit_en = 1'b1; commit_rd = 5'd5; commit_rob_id = 4'd3; commit_val = 32'hDEADBEEF;
    tick(); idle();
    #1;
    chk("cmt_busy", {31'd0, rs1_busy}, 32'd0);
    chk("cmt_val", rs1_val, 32'hDEADBEEF);

    // stale commit
    issue_en = 1'b1; issue_rd = 5'd7; issue_rob_id = 4'd2;
    tick();
    issue_rob_id = 4'd9;
    tick(); idle();
    commit_en = 1'b1; commit_rd = 5'd7; commit_rob_id = 4'd2; commit_val = 32'h11;
    tick(); idle();
    rs2_id = 5'd7;
    #1;
    chk("stale_val", rs2_val, 32'h11);
    chk("stale_busy", {31'd0, rs2_busy}, 32'd1);
    chk("stale_tag", {28'd0, rs2_tag}, 32'd9);

    // same-cycle collision on r4 (previously renamed to tag 1)
    issue_en = 1'b1; issue_rd = 5'd4; issue_rob_id = 4'd1;
    tick();
    issue_rob_id = 4'd6;
    commit_en = 1'b1; commit_rd = 5'd4; commit_rob_id = 4'd1; commit_val = 32'h55;
    tick(); idle();
    rs1_id = 5'd4;
    #1;
    chk("coll_val", rs1_val, 32'h55);
    chk("coll_busy", {31'd0, rs1_busy}, 32'd1);
    chk("coll_tag", {28'd0, rs1_tag}, 32'd6);

    // rdy low holds state
    rdy = 1'b0;
    issue_en = 1'b1; issue_rd = 5'd10; issue_rob_id = 4'd7;
    commit_en = 1'b1; commit_rd = 5'd10; commit_rob_id = 4'd7; commit_val = 32'h99;
    tick(); idle();
    rdy = 1'b1;
    rs1_id = 5'd10;
    #1;
    chk("rdy_val", rs1_val, 32'd0);
    chk("rdy_busy", {31'd0, rs1_busy}, 32'd0);

    // flush
    issue_en = 1'b1; issue_rd = 5'd3; issue_rob_id = 4'd1;
    tick();
    issue_rd = 5'd8; issue_rob_id = 4'd2;
    tick();
    issue_rd = 5'd12; issue_rob_id = 4'd3;
    tick();
    rs1_id = 5'd12;
    #1;
    chk("pre_flush_busy", {31'd0, rs1_busy}, 32'd1);
    clear = 1'b1;
    issue_rd = 5'd9; issue_rob_id = 4'd4;
    commit_en = 1'b1; commit_rd = 5'd8; commit_rob_id = 4'd15; commit_val = 32'h1234;
    tick(); idle();
    rs1_id = 5'd3; rs2_id = 5'd8;
    #1;
    chk("flush_r3_busy", {31'd0, rs1_busy}, 32'd0);
    chk("flush_r8_busy", {31'd0, rs2_busy}, 32'd0);
    chk("flush_r8_val", rs2_val, 32'h1234);
    rs1_id = 5'd12; rs2_id = 5'd9;
    #1;
    chk("flush_r12_busy", {31'd0, rs1_busy}, 32'd0);
    chk("flush_r9_busy", {31'd0, rs2_busy}, 32'd0);

    // x0 ignores issue and commit
    issue_en = 1'b1; issue_rd = 5'd0; issue_rob_id = 4'd5;
    commit_en = 1'b1; commit_rd = 5'd0; commit_rob_id = 4'd5; commit_val = 32'hFF;
    tick(); idle();
    rs1_id = 5'd0;
    #1;
    chk("x0_val", rs1_val, 32'd0);
    chk("x0_busy", {31'd0, rs1_busy}, 32'd0);
    chk("x0_tag", {28'd0, rs1_tag}, 32'd0);

    // same-cycle commit visibility on rs2
    issue_en = 1'b1; issue_rd = 5'd6; issue_rob_id = 4'd5;
    tick(); idle();
    commit_en = 1'b1; commit_rd = 5'd6; commit_rob_id = 4'd5; commit_val = 32'hA5;
    rs2_id = 5'd6;
    #1;
`ifdef RF_BYPASS_EN
    chk("byp_val", rs2_val, 32'hA5);
    chk("byp_busy", {31'd0, rs2_busy}, 32'd0);
`else
    chk("nobyp_val", rs2_val, 32'd0);
    chk("nobyp_busy", {31'd0, rs2_busy}, 32'd1);
    chk("nobyp_tag", {28'd0, rs2_tag}, 32'd5);
`endif
    tick(); idle();
    #1;
    chk("post_cmt_val", rs2_val, 32'hA5);
    chk("post_cmt_busy", {31'd0, rs2_busy}, 32'd0);

    // asynchronous reset mid-cycle
    issue_en = 1'b1; issue_rd = 5'd7; issue_rob_id = 4'd11;
    tick(); idle();
    #2;
    rst = 1'b0;
    rs1_id = 5'd5; rs2_id = 5'd7;
    #1;
    chk("arst_r5_val", rs1_val, 32'd0);
    chk("arst_r7_val", rs2_val, 32'd0);
    chk("arst_r7_busy", {31'd0, rs2_busy}, 32'd0);
    chk("arst_r7_tag", {28'd0, rs2_tag}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
